// File: rtl/vga_scan.sv
// VGA scan engine: h/v timing counters, sync generation, framebuffer addressing
// and a three-stage pin pipeline so sync, status and colour describe the same pixel.
module vga_scan #(
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_ACTIVE    = 400,
   parameter int   V_FP        = 12,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 35,
   parameter logic HS_POL      = 1'b0,
   parameter logic VS_POL      = 1'b1,
   parameter int   SCALE_SHIFT = 1,
   parameter int   BPP         = 1,
   parameter int   AX_W        = 9,
   parameter int   AY_W        = 8
) (
   input  logic            clk,
   input  logic            rst,
   output logic            HS,
   output logic            VS,
   output logic [2:0]      R,
   output logic [2:0]      G,
   output logic [1:0]      B,
   output logic [AX_W-1:0] fb_x,
   output logic [AY_W-1:0] fb_y,
   output logic            fb_en,
   input  logic [BPP-1:0]  fb_data,
   input  logic [7:0]      fg_color,
   input  logic [7:0]      bg_color,
   output logic            frame_start,
   output logic            vblank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

   // Per-stage status flags; the idle pattern is "blanked, no sync, no frame start".
   localparam int F_HS = 4;
   localparam int F_VS = 3;
   localparam int F_VB = 2;
   localparam int F_FS = 1;
   localparam int F_BL = 0;
   localparam logic [4:0] FLAGS_IDLE = 5'b00101;

   logic [HW-1:0]   h_reg;
   logic [VW-1:0]   v_reg;
   logic            h_act;
   logic            v_act;
   logic            at_origin;
   logic [4:0]      flags_next;
   logic [4:0]      st1_reg;
   logic [4:0]      st2_reg;
   logic [AX_W-1:0] fb_x_reg;
   logic [AY_W-1:0] fb_y_reg;
   logic            fb_en_reg;
   logic [7:0]      pix_rgb;
   logic [7:0]      rgb_reg;
   logic            hs_reg;
   logic            vs_reg;
   logic            vblank_reg;
   logic            fs_reg;

   always_comb begin
      h_act     = (h_reg < H_ACT);
      v_act     = (v_reg < V_ACT);
      at_origin = (h_reg == '0) && (v_reg == '0);
      flags_next       = FLAGS_IDLE;
      flags_next[F_HS] = (h_reg >= H_SS) && (h_reg < H_SE);
      flags_next[F_VS] = (v_reg >= V_SS) && (v_reg < V_SE);
      flags_next[F_VB] = !v_act;
      flags_next[F_FS] = at_origin;
      flags_next[F_BL] = !(h_act && v_act);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_reg <= '0;
         v_reg <= '0;
      end else if (h_reg == H_LAST) begin
         h_reg <= '0;
         v_reg <= (v_reg == V_LAST) ? '0 : v_reg + VW'(1);
      end else begin
         h_reg <= h_reg + HW'(1);
      end
   end

   // Stage 1 issues the RAM address; stage 2 waits out the RAM read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         fb_x_reg  <= '0;
         fb_y_reg  <= '0;
         fb_en_reg <= 1'b0;
         st1_reg   <= FLAGS_IDLE;
         st2_reg   <= FLAGS_IDLE;
      end else begin
         st1_reg <= flags_next;
         st2_reg <= st1_reg;
         if (h_act && v_act) begin
            fb_x_reg  <= AX_W'(h_reg >> SCALE_SHIFT);
            fb_y_reg  <= AY_W'(v_reg >> SCALE_SHIFT);
            fb_en_reg <= 1'b1;
         end else begin
            fb_x_reg  <= '0;
            fb_y_reg  <= '0;
            fb_en_reg <= 1'b0;
         end
      end
   end

   generate
      if (BPP == 1) begin : g_palette
         logic [7:0] fg_shadow_reg;
         logic [7:0] bg_shadow_reg;
         // Palette is only sampled at the frame origin so a frame never mixes colours.
         always_ff @(posedge clk) begin
            if (rst || at_origin) begin
               fg_shadow_reg <= fg_color;
               bg_shadow_reg <= bg_color;
            end
         end
         assign pix_rgb = fb_data[0] ? fg_shadow_reg : bg_shadow_reg;
      end else begin : g_direct
         assign pix_rgb = fb_data[7:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_reg     <= ~HS_POL;
         vs_reg     <= ~VS_POL;
         vblank_reg <= 1'b1;
         fs_reg     <= 1'b0;
         rgb_reg    <= 8'h00;
      end else begin
         hs_reg     <= st2_reg[F_HS] ? HS_POL : ~HS_POL;
         vs_reg     <= st2_reg[F_VS] ? VS_POL : ~VS_POL;
         vblank_reg <= st2_reg[F_VB];
         fs_reg     <= st2_reg[F_FS];
         rgb_reg    <= st2_reg[F_BL] ? 8'h00 : pix_rgb;
      end
   end

   assign HS          = hs_reg;
   assign VS          = vs_reg;
   assign R           = rgb_reg[7:5];
   assign G           = rgb_reg[4:2];
   assign B           = rgb_reg[1:0];
   assign fb_x        = fb_x_reg;
   assign fb_y        = fb_y_reg;
   assign fb_en       = fb_en_reg;
   assign frame_start = fs_reg;
   assign vblank      = vblank_reg;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: three configurations run side by side, each compared every
// cycle against a model that derives pin values from the cycle count since reset.
module tb_vga_scan;

   localparam int FT_A = 800 * 449;
   localparam int FT_B = 12 * 7;
   localparam int FT_C = 24 * 12;
   localparam int N_CYC = 42600;

   logic clk;
   int total;
   int bad;

   logic       rst_a, HS_a, VS_a, fben_a, fbd_a, fs_a, vb_a;
   logic [2:0] R_a, G_a;
   logic [1:0] B_a;
   logic [8:0] fbx_a;
   logic [7:0] fby_a, fg_a, bg_a;

   logic       rst_b, HS_b, VS_b, fben_b, fs_b, vb_b;
   logic [2:0] R_b, G_b;
   logic [1:0] B_b;
   logic [2:0] fbx_b;
   logic [1:0] fby_b;
   logic [7:0] fbd_b;

   logic       rst_c, HS_c, VS_c, fben_c, fbd_c, fs_c, vb_c;
   logic [2:0] R_c, G_c;
   logic [1:0] B_c;
   logic [2:0] fbx_c;
   logic [1:0] fby_c;
   logic [7:0] fg_c, bg_c;

   logic [7:0] mem_b [32];
   logic       mem_c [32];
   logic [7:0] fg_fr [3][256];
   logic [7:0] bg_fr [3][256];

   vga_scan dut_a (
      .clk(clk), .rst(rst_a), .HS(HS_a), .VS(VS_a), .R(R_a), .G(G_a), .B(B_a),
      .fb_x(fbx_a), .fb_y(fby_a), .fb_en(fben_a), .fb_data(fbd_a),
      .fg_color(fg_a), .bg_color(bg_a), .frame_start(fs_a), .vblank(vb_a)
   );

   vga_scan #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b1), .SCALE_SHIFT(0), .BPP(8), .AX_W(3), .AY_W(2)
   ) dut_b (
      .clk(clk), .rst(rst_b), .HS(HS_b), .VS(VS_b), .R(R_b), .G(G_b), .B(B_b),
      .fb_x(fbx_b), .fb_y(fby_b), .fb_en(fben_b), .fb_data(fbd_b),
      .fg_color(8'h00), .bg_color(8'h00), .frame_start(fs_b), .vblank(vb_b)
   );

   vga_scan #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .SCALE_SHIFT(1), .BPP(1), .AX_W(3), .AY_W(2)
   ) dut_c (
      .clk(clk), .rst(rst_c), .HS(HS_c), .VS(VS_c), .R(R_c), .G(G_c), .B(B_c),
      .fb_x(fbx_c), .fb_y(fby_c), .fb_en(fben_c), .fb_data(fbd_c),
      .fg_color(fg_c), .bg_color(bg_c), .frame_start(fs_c), .vblank(vb_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read framebuffer models, one cycle of latency.
   always @(posedge clk) begin
      fbd_a <= fbx_a[0] ^ fby_a[0];
      fbd_b <= mem_b[{fby_b, fbx_b}];
      fbd_c <= mem_c[{fby_c, fbx_c}];
   end

   function automatic logic [7:0] pix_color(input int id, input int x, input int y, input int f);
      logic [7:0] c;
      c = 8'h00;
      case (id)
         0: c = (((x ^ y) & 1) != 0) ? fg_fr[0][f] : bg_fr[0][f];
         1: c = mem_b[y * 8 + x];
         default: c = mem_c[y * 8 + x] ? fg_fr[2][f] : bg_fr[2][f];
      endcase
      return c;
   endfunction

   task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Cycle n counts from the first cycle after the reset edge; pins show counter
   // cycle n-3 and the address port shows counter cycle n-1.
   task automatic check_inst(input int id, input string nm, input int n,
                             input int ha, input int hfp, input int hsw, input int hbp,
                             input int va, input int vfp, input int vsw, input int vbp,
                             input logic hpol, input logic vpol, input int sh,
                             input logic [11:0] pins_act, input logic [32:0] fb_act);
      int ht, vt, p, h, v;
      logic act, ehs, evs;
      logic [7:0] c;
      logic [11:0] pins_exp;
      logic [32:0] fb_exp;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      if (n < 3) begin
         pins_exp = {~hpol, ~vpol, 8'h00, 1'b1, 1'b0};
      end else begin
         p = n - 3;
         h = p % ht;
         v = (p / ht) % vt;
         act = (h < ha) && (v < va);
         ehs = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : ~hpol;
         evs = (v >= va + vfp && v < va + vfp + vsw) ? vpol : ~vpol;
         c = act ? pix_color(id, h >> sh, v >> sh, p / (ht * vt)) : 8'h00;
         pins_exp = {ehs, evs, c, logic'(v >= va), logic'(h == 0 && v == 0)};
      end
      check({nm, "_pins"}, 40'(pins_act), 40'(pins_exp));
      if (n < 1) begin
         fb_exp = '0;
      end else begin
         p = n - 1;
         h = p % ht;
         v = (p / ht) % vt;
         act = (h < ha) && (v < va);
         fb_exp = act ? {1'b1, 16'(h >> sh), 16'(v >> sh)} : 33'h0;
      end
      check({nm, "_fb"}, 40'(fb_act), 40'(fb_exp));
   endtask

   initial begin
      int n_a, n_b, n_c;
      bit a_mid_done;
      total = 0;
      bad = 0;
      n_a = -1;
      n_b = -1;
      n_c = -1;
      a_mid_done = 1'b0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      fg_a = 8'hFF;
      bg_a = 8'h25;
      fg_c = 8'($urandom);
      bg_c = 8'($urandom);
      for (int i = 0; i < 32; i++) begin
         mem_b[i] = 8'($urandom);
         mem_c[i] = 1'($urandom);
      end

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(negedge clk);
         if (n_a >= 0)
            check_inst(0, "a", n_a, 640, 16, 96, 48, 400, 12, 2, 35, 1'b0, 1'b1, 1,
                       {HS_a, VS_a, R_a, G_a, B_a, vb_a, fs_a},
                       {fben_a, 16'(fbx_a), 16'(fby_a)});
         if (n_b >= 0)
            check_inst(1, "b", n_b, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b1, 0,
                       {HS_b, VS_b, R_b, G_b, B_b, vb_b, fs_b},
                       {fben_b, 16'(fbx_b), 16'(fby_b)});
         if (n_c >= 0)
            check_inst(2, "c", n_c, 16, 2, 4, 2, 8, 1, 2, 1, 1'b1, 1'b0, 1,
                       {HS_c, VS_c, R_c, G_c, B_c, vb_c, fs_c},
                       {fben_c, 16'(fbx_c), 16'(fby_c)});

         // Hand-computed anchors for the default configuration.
         if (n_a == 0) begin
            check("a_rst_hs", 40'(HS_a), 40'd1);
            check("a_rst_vblank", 40'(vb_a), 40'd1);
            check("a_rst_fben", 40'(fben_a), 40'd0);
         end
         if (n_a == 1 || n_a == 2) check("a_fbx_0", 40'(fbx_a), 40'd0);
         if (n_a == 3 || n_a == 4) check("a_fbx_1", 40'(fbx_a), 40'd1);
         if (n_a == 2) check("a_fs_early", 40'(fs_a), 40'd0);
         if (n_a == 3) begin
            check("a_fs", 40'(fs_a), 40'd1);
            check("a_rgb_bg", 40'({R_a, G_a, B_a}), 40'h25);
         end
         if (n_a == 5) check("a_rgb_fg", 40'({R_a, G_a, B_a}), 40'hFF);
         if (n_a == 641) check("a_fben_hblank", 40'(fben_a), 40'd0);
         if (n_a == 643) check("a_rgb_hblank", 40'({R_a, G_a, B_a}), 40'h00);
         if (n_a == 658) check("a_hs_pre", 40'(HS_a), 40'd1);
         if (n_a == 659) check("a_hs_fall", 40'(HS_a), 40'd0);
         if (n_a == 754) check("a_hs_last", 40'(HS_a), 40'd0);
         if (n_a == 755) check("a_hs_rise", 40'(HS_a), 40'd1);
         if (n_a == 1601) check("a_fby_line2", 40'({fben_a, fby_a}), 40'h101);
         if (n_b == 3) check("b_rgb_00", 40'({R_b, G_b, B_b}), 40'(mem_b[0]));
         if (n_b == 86) check("b_fs_pre", 40'(fs_b), 40'd0);
         if (n_b == 87) check("b_fs_frame1", 40'(fs_b), 40'd1);
         if (n_b == 12) check("b_hs_on", 40'(HS_b), 40'd0);
         if (n_b == 14) check("b_hs_off", 40'(HS_b), 40'd1);
         if (n_c == 3) check("c_fs", 40'(fs_c), 40'd1);
         if (n_c == 21) check("c_hs_on", 40'(HS_c), 40'd1);
         if (n_c == 25) check("c_hs_off", 40'(HS_c), 40'd0);

         // Default instance: reset once mid-line at counter (300, 50).
         if (n_a < 0 || (n_a == 50 * 800 + 300 && !a_mid_done)) begin
            if (n_a >= 0) a_mid_done = 1'b1;
            rst_a = 1'b1;
            n_a = 0;
         end else begin
            rst_a = 1'b0;
            if (n_a % FT_A == 0) begin
               fg_fr[0][n_a / FT_A] = fg_a;
               bg_fr[0][n_a / FT_A] = bg_a;
            end
            n_a++;
         end

         if (n_b < 0 || $urandom_range(0, 1999) == 0) begin
            rst_b = 1'b1;
            n_b = 0;
         end else begin
            rst_b = 1'b0;
            n_b++;
         end

         if (n_c < 0 || $urandom_range(0, 2999) == 0) begin
            rst_c = 1'b1;
            n_c = 0;
         end else begin
            rst_c = 1'b0;
            if ($urandom_range(0, 99) == 0) fg_c = 8'($urandom);
            if ($urandom_range(0, 99) == 0) bg_c = 8'($urandom);
            if (n_c == FT_C + 4 * 24) fg_c = 8'hE0;
            if (n_c % FT_C == 0) begin
               fg_fr[2][n_c / FT_C] = fg_c;
               bg_fr[2][n_c / FT_C] = bg_c;
            end
            n_c++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
